// File: rtl/adc_pwm_cpu_cpu_debug_mem_ctrl_if.sv
// adc_pwm_cpu_cpu_debug_mem_ctrl_if: Avalon-style CPU slave port into the debug monitor RAM
interface adc_pwm_cpu_cpu_debug_mem_ctrl_if #(
    parameter int ADDR_W = 8
) ();
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_read;
    logic              cpu_write;
    logic [31:0]       cpu_writedata;
    logic [3:0]        cpu_byteenable;
    logic              cpu_debugaccess;
    logic [31:0]       cpu_readdata;
    logic              cpu_waitrequest;

    modport master (
        output cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable, cpu_debugaccess,
        input  cpu_readdata, cpu_waitrequest
    );

    modport slave (
        input  cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable, cpu_debugaccess,
        output cpu_readdata, cpu_waitrequest
    );
endinterface

// File: rtl/adc_pwm_cpu_cpu_debug_mem_ctrl.sv
// adc_pwm_cpu_cpu_debug_mem_ctrl: executes JTAG monitor-RAM commands and arbitrates a CPU port, JTAG first
// Optional DEBUG_MEM_WRITE_PROTECT_EN: discards non-debug CPU writes at or above PROTECT_BASE.
module adc_pwm_cpu_cpu_debug_mem_ctrl #(
    parameter int                ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] PROTECT_BASE = ADDR_W'('h80)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [37:0]                            jdo,
    input  logic                                   take_action_ocimem_a,
    input  logic                                   take_no_action_ocimem_a,
    input  logic                                   take_action_ocimem_b,
    adc_pwm_cpu_cpu_debug_mem_ctrl_if.slave        bus,
    output logic [31:0]                            MonDReg,
    output logic                                   mon_valid,
    output logic [ADDR_W-1:0]                      jtag_addr,
    output logic                                   cmd_overrun
);
    typedef enum logic [1:0] {IDLE, J_RD, J_CAP, C_RD} state_t;

    state_t            state;
    logic [31:0]       mem [2**ADDR_W];
    logic              pend_rd, pend_wr;
    logic [31:0]       pend_data;
    logic              busy, any_strobe, multi_strobe, blocked, j_wr, cpu_wr;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_be;
    logic              unused;

`ifdef DEBUG_MEM_WRITE_PROTECT_EN
    assign blocked = bus.cpu_address >= PROTECT_BASE && !bus.cpu_debugaccess;
    assign unused  = &{1'b0, jdo[37:35], jdo[1:0]};
`else
    assign blocked = 1'b0;
    assign unused  = &{1'b0, jdo[37:35], jdo[1:0], PROTECT_BASE, bus.cpu_debugaccess};
`endif

    always_comb begin
        busy         = pend_rd || pend_wr || state != IDLE;
        any_strobe   = take_action_ocimem_a || take_no_action_ocimem_a || take_action_ocimem_b;
        multi_strobe = (take_action_ocimem_b && (take_action_ocimem_a || take_no_action_ocimem_a)) ||
                       (take_action_ocimem_a && take_no_action_ocimem_a);
        j_wr         = state == IDLE && pend_wr;
        cpu_wr       = !busy && bus.cpu_write && !blocked;
        wr_addr      = j_wr ? jtag_addr : bus.cpu_address;
        wr_data      = j_wr ? pend_data : bus.cpu_writedata;
        wr_be        = j_wr ? 4'hf : bus.cpu_byteenable;
        // a blocked or accepted write never stalls; reads always take one wait state
        bus.cpu_waitrequest = state == C_RD ? 1'b0 : bus.cpu_write ? busy : bus.cpu_read;
    end

    always_ff @(posedge clk)
        if (j_wr || cpu_wr)
            for (int i = 0; i < 4; i++)
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state            <= IDLE;
            pend_rd          <= 1'b0;
            pend_wr          <= 1'b0;
            pend_data        <= '0;
            MonDReg          <= '0;
            mon_valid        <= 1'b0;
            jtag_addr        <= '0;
            cmd_overrun      <= 1'b0;
            bus.cpu_readdata <= '0;
        end else begin
            mon_valid <= 1'b0;
            if ((busy && any_strobe) || multi_strobe) cmd_overrun <= 1'b1;
            // capture only when fully idle; consumption below needs a pending command, so they never collide
            if (!busy) begin
                if (take_action_ocimem_b) begin
                    pend_wr   <= 1'b1;
                    pend_data <= jdo[34:3];
                end else if (take_action_ocimem_a) begin
                    jtag_addr <= jdo[ADDR_W+1:2];
                    pend_rd   <= jdo[34];
                end else if (take_no_action_ocimem_a) begin
                    jtag_addr <= jtag_addr + 1'b1;
                    pend_rd   <= 1'b1;
                end
            end
            unique case (state)
                IDLE:
                    if (pend_wr) begin
                        pend_wr   <= 1'b0;
                        jtag_addr <= jtag_addr + 1'b1;
                    end else if (pend_rd) begin
                        pend_rd <= 1'b0;
                        state   <= J_RD;
                    end else if (bus.cpu_read && !bus.cpu_write) begin
                        bus.cpu_readdata <= mem[bus.cpu_address];
                        state            <= C_RD;
                    end
                J_RD: begin
                    MonDReg   <= mem[jtag_addr];
                    mon_valid <= 1'b1;
                    state     <= J_CAP;
                end
                J_CAP: state <= IDLE;
                C_RD:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: doc/adc_pwm_cpu_cpu_debug_mem_ctrl.md
Name: adc_pwm_cpu_cpu_debug_mem_ctrl

Overview:
System-clock-side consumer of the debug slave's command strobes and 38-bit jdo word. It owns the debug monitor RAM (2^ADDR_W x 32) and executes JTAG address-load, read, auto-increment-read and write commands. It returns read data on MonDReg/mon_valid. It also arbitrates a CPU-side Avalon-style slave port into the same RAM, with JTAG given priority.

Parameters:
ADDR_W, 8, word-address width; RAM depth is 2^ADDR_W words of 32 bits.
PROTECT_BASE, 8'h80, first protected word address (used only with the optional feature).

Ports:
clk  in  1  system clock; all logic is rising-edge.
reset  in  1  asynchronous, active-high reset.
jdo  in  38  JTAG data word from the debug slave sysclk stage.
take_action_ocimem_a  in  1  one-cycle strobe: load address, optionally read.
take_no_action_ocimem_a  in  1  one-cycle strobe: increment address, then read.
take_action_ocimem_b  in  1  one-cycle strobe: write data, then increment address.
cpu_address  in  ADDR_W  CPU word address.
cpu_read  in  1  CPU read request.
cpu_write  in  1  CPU write request.
cpu_writedata  in  32  CPU write data.
cpu_byteenable  in  4  CPU byte lanes.
cpu_debugaccess  in  1  CPU is in debug mode.
cpu_readdata  out  32  CPU read data.
cpu_waitrequest  out  1  stall for the CPU port.
MonDReg  out  32  last JTAG read result.
mon_valid  out  1  one-cycle pulse when MonDReg updates.
jtag_addr  out  ADDR_W  current JTAG word address.
cmd_overrun  out  1  sticky flag: a strobe was dropped.

Behaviour:
- Reset values: MonDReg=0, mon_valid=0, jtag_addr=0, cpu_readdata=0, cpu_waitrequest=0, cmd_overrun=0. FSM goes to IDLE and the pending command is cleared. RAM contents are not reset.
- Command capture (edge after a strobe, into a one-deep pending register):
  - ocimem_a: jtag_addr<=jdo[ADDR_W+1:2]; a read is pending only if jdo[34]=1, otherwise nothing is pending.
  - no_action_a: jtag_addr<=jtag_addr+1; a read is pending.
  - ocimem_b: write data jdo[34:3] is pending at the current jtag_addr.
- Address wrap: jtag_addr increments modulo 2^ADDR_W, so all-ones becomes 0.
- Overrun: a strobe that arrives while a command is pending or the FSM is not IDLE is dropped, and cmd_overrun is set (sticky until reset).
- Multiple strobes in one cycle: priority is ocimem_b > ocimem_a > no_action_a. The lower strobes are dropped and set cmd_overrun.
- RAM: single port, synchronous, 1-cycle read latency, byte-write enables.
- FSM states: IDLE, J_RD, J_CAP, C_RD.
  - IDLE with a pending read -> J_RD, which drives the RAM with jtag_addr.
  - J_RD -> J_CAP: MonDReg<=ram_q and mon_valid=1 for exactly one cycle. Then -> IDLE.
  - IDLE with a pending write: all 4 bytes are written at jtag_addr on that edge. jtag_addr then increments and the FSM stays in IDLE.
  - IDLE with no pending command, cpu_write=1: waitrequest stays 0 and the RAM is written on that edge using cpu_byteenable.
  - IDLE with no pending command, cpu_read=1: waitrequest=1 and the read is issued -> C_RD. In C_RD, cpu_readdata<=ram_q and waitrequest=0 (exactly one wait state), then -> IDLE.
  - A CPU request in any cycle where a JTAG command is pending or the FSM is not IDLE sees waitrequest=1. The CPU must hold its request.
- Latency: a JTAG read strobe in cycle T gives mon_valid=1 in cycle T+3. A JTAG write strobe in cycle T updates the RAM at the end of T+1.
- cpu_read and cpu_write asserted together is illegal; the write is serviced and the read is ignored.
- Reset mid-operation: any in-flight read is abandoned and no mon_valid is produced.

Optional Feature:
DEBUG_MEM_WRITE_PROTECT_EN.
- Defined: a CPU write to an address >= PROTECT_BASE while cpu_debugaccess=0 is accepted but discarded; waitrequest is still 0 and the RAM is unchanged. JTAG writes are never blocked.
- Undefined: PROTECT_BASE and cpu_debugaccess are ignored and every CPU write is performed.

Test Plan:
- ocimem_a with jdo[9:2]=8'h10, jdo[34]=0; then ocimem_b with jdo[34:3]=32'hDEADBEEF -> RAM[0x10]=DEADBEEF and jtag_addr=0x11.
- ocimem_a with jdo[9:2]=8'h10, jdo[34]=1 at cycle T -> MonDReg=DEADBEEF and mon_valid high only in T+3. Then no_action_a -> jtag_addr=0x11 and MonDReg=RAM[0x11].
- jtag_addr=0xFF, then no_action_a -> jtag_addr=0x00 and MonDReg=RAM[0x00].
- CPU read of 0x10 held during a pending JTAG read -> waitrequest stays 1 until the JTAG read finishes. cpu_readdata=DEADBEEF after one further wait state.
- CPU write 0x90 with data 12345678, byteenable 4'b0011, debugaccess=0: macro on -> RAM unchanged; macro off -> low half of the word = 5678.
- ocimem_a and no_action_a in the same cycle, then a strobe while in J_RD -> cmd_overrun=1 and held until reset; assert reset mid-J_RD -> outputs at reset values and no mon_valid.
